ysyx_22040895_id_ctrl: RTL

Decode-stage sequencing controller between the IFU and the IDU/EXU boundary. It accepts fetched instructions over a valid/ready handshake, buffers up to two of them so that `if_ready_o` carries no combinational path from `ex_ready_i`, and presents the head instruction and its PC to the IDU. It inserts load-use bubbles, drops all buffered instructions on a branch/jump redirect, and counts inserted bubbles.

---
 rtl/ysyx_22040895_id_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ysyx_22040895_id_ctrl.sv
// Decode-stage sequencer: two-entry skid buffer between the IFU and IDU/EXU with an optional
// load-use interlock and bubble counter, enabled by defining YSYX_22040895_HAZARD_EN.
module ysyx_22040895_id_ctrl #(
   parameter int unsigned PC_W   = 64,
   parameter int unsigned INST_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_valid_i,
   input  logic [INST_W-1:0] if_inst_i,
   input  logic [PC_W-1:0]   if_pc_i,
   output logic              if_ready_o,
   output logic              id_valid_o,
   output logic [INST_W-1:0] id_inst_o,
   output logic [PC_W-1:0]   id_pc_o,
   input  logic              ex_ready_i,
   input  logic              ex_load_i,
   input  logic [4:0]        ex_rd_i,
   input  logic              flush_i,
   output logic [31:0]       bubble_cnt_o
);

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StTwo   = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [INST_W-1:0] head_inst_q, head_inst_d;
   logic [PC_W-1:0]   head_pc_q, head_pc_d;
   logic [INST_W-1:0] skid_inst_q, skid_inst_d;
   logic [PC_W-1:0]   skid_pc_q, skid_pc_d;

   logic hazard;
   logic push;
   logic pop;

`ifdef YSYX_22040895_HAZARD_EN
   logic [6:0]  opcode;
   logic        uses_rs1;
   logic        uses_rs2;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   assign opcode = head_inst_q[6:0];

   always_comb begin
      uses_rs1 = 1'b1;
      uses_rs2 = 1'b0;
      unique case (opcode)
         7'b0110111, 7'b0010111, 7'b1101111: uses_rs1 = 1'b0;
         7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011: uses_rs2 = 1'b1;
         default: ;
      endcase
   end

   assign hazard = ex_load_i && (ex_rd_i != 5'd0) &&
                   ((uses_rs1 && (head_inst_q[19:15] == ex_rd_i)) ||
                    (uses_rs2 && (head_inst_q[24:20] == ex_rd_i)));

   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if ((state_q != StEmpty) && hazard && !flush_i) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bubble_cnt_q <= '0;
      end else begin
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bubble_cnt_o = bubble_cnt_q;
`else
   // Without the interlock, load-use ordering is left to forwarding or the compiler.
   logic unused_ex;
   assign unused_ex    = ^{ex_load_i, ex_rd_i};
   assign hazard       = 1'b0;
   assign bubble_cnt_o = '0;
`endif

   assign if_ready_o = (state_q != StTwo) && !rst;
   assign id_valid_o = (state_q != StEmpty) && !hazard;
   assign id_inst_o  = head_inst_q;
   assign id_pc_o    = head_pc_q;

   assign push = if_valid_i && if_ready_o;
   assign pop  = id_valid_o && ex_ready_i;

   always_comb begin
      state_d     = state_q;
      head_inst_d = head_inst_q;
      head_pc_d   = head_pc_q;
      skid_inst_d = skid_inst_q;
      skid_pc_d   = skid_pc_q;
      if (flush_i) begin
         state_d = StEmpty;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (push) begin
                  state_d     = StOne;
                  head_inst_d = if_inst_i;
                  head_pc_d   = if_pc_i;
               end
            end
            StOne: begin
               if (push && pop) begin
                  head_inst_d = if_inst_i;
                  head_pc_d   = if_pc_i;
               end else if (push) begin
                  state_d     = StTwo;
                  skid_inst_d = if_inst_i;
                  skid_pc_d   = if_pc_i;
               end else if (pop) begin
                  state_d = StEmpty;
               end
            end
            StTwo: begin
               if (pop) begin
                  state_d     = StOne;
                  head_inst_d = skid_inst_q;
                  head_pc_d   = skid_pc_q;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StEmpty;
         head_inst_q <= '0;
         head_pc_q   <= '0;
         skid_inst_q <= '0;
         skid_pc_q   <= '0;
      end else begin
         state_q     <= state_d;
         head_inst_q <= head_inst_d;
         head_pc_q   <= head_pc_d;
         skid_inst_q <= skid_inst_d;
         skid_pc_q   <= skid_pc_d;
      end
   end

endmodule
